ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage that consumes the decode-stage bundle: aluop, alusel, two 32-bit operands, write-enable and destination.
- Contains the ID/EX pipeline register, a single-cycle logic/shift/arith datapath, an iterative 32-cycle divider with HI/LO registers, and the EX/MEM output register.
- Its registered outputs (wreg/wd/wdata) travel down the pipe and return to decode as the regfile write port.

Parameters:
- DIV_CYCLES, 32, iterations of the radix-2 restoring divider (fixed at 32 for 32-bit operands).

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush_i  in  1  squash the ID/EX contents and abort any divide in progress.
- aluop_i  in  8  operation code from decode.
- alusel_i  in  3  result class from decode.
- reg1_i  in  32  operand 1 (rs value, or shamt in [4:0] for shifts).
- reg2_i  in  32  operand 2 (rt value or immediate).
- wreg_i  in  1  instruction writes a GPR.
- wd_i  in  5  GPR destination.
- stall_o  out  1  hold decode; ID/EX does not capture while high.
- wreg_o  out  1  registered GPR write enable to MEM.
- wd_o  out  5  registered destination.
- wdata_o  out  32  registered result.
- hi_o  out  32  HI register.
- lo_o  out  32  LO register.

Behaviour:
- Reset (async): the ID/EX register, EX/MEM register, hi_o and lo_o all go to 0. The divider FSM goes to IDLE. stall_o is 0.
- ID/EX capture: loads the inputs on an edge when stall_o=0 and flush_i=0. flush_i=1 loads all zeros (alusel=RES_NOP, wreg=0); flush has priority over stall.
- Latency: an instruction presented at edge N is captured at N. Its result appears on wreg_o/wd_o/wdata_o after edge N+1.
- Results by alusel (all arithmetic mod 2^32):
  - RES_LOGIC: OR, AND, XOR, NOR of reg1, reg2.
  - RES_SHIFT: SLL, SRL, SRA of reg2 by reg1[4:0].
  - RES_ARITH: ADDU, SUBU (reg1-reg2), SLT (signed, result 0/1), SLTU (unsigned, result 0/1).
  - RES_MOVE: MFHI and MFLO return the current hi_o/lo_o.
  - Unknown aluop inside a known class: wdata=0, wreg passes through.
  - RES_NOP: wreg_o=0, wdata_o=0.
- Writes to r0 pass through unchanged; the regfile ignores them.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE: if the ID/EX register holds DIV or DIVU, then stall_o=1.
    - Divisor nonzero: latch the magnitudes (absolute values for DIV), count=0, go to BUSY.
    - Divisor 0: go directly to DONE with q=0xFFFF_FFFF, r=dividend.
  - BUSY: stall_o=1, one quotient bit per cycle. After count reaches 31, go to DONE. Stall is 33 cycles total, counting the IDLE cycle.
  - DONE: stall_o=0; write lo_o=q and hi_o=r on the exiting edge. For DIV, negate q if the operand signs differ; the remainder takes the dividend's sign. Then go to IDLE. A new instruction is captured on the same edge.
  - -2^31 / -1: q=0x8000_0000, r=0 (natural wrap, no trap).
- While stall_o=1 or in DONE, the EX/MEM register loads a bubble: wreg_o=0, wd_o=0, wdata_o=0.
- MFHI/MFLO immediately following a DIV sees the new HI/LO, because HI/LO are written before MFHI/MFLO reach EX.
- flush_i during BUSY: FSM to IDLE on that edge, HI/LO unchanged, stall_o=0 in the next cycle.
- rst mid-divide: immediate return to IDLE with HI/LO=0.

Decomposition:
- Package cpu_defs_pkg holds the shared codes.
- alusel codes: RES_NOP=3'b000, RES_LOGIC=3'b001, RES_SHIFT=3'b010, RES_MOVE=3'b011, RES_ARITH=3'b100, RES_DIV=3'b101.
- aluop codes: OR=8'b00100101, AND=8'b00100100, XOR=8'b00100110, NOR=8'b00100111, SLL=8'b01111100, SRL=8'b00000010, SRA=8'b00000011, ADDU=8'b00100001, SUBU=8'b00100011, SLT=8'b00101010, SLTU=8'b00101011, MFHI=8'b00010000, MFLO=8'b00010010, DIV=8'b00011010, DIVU=8'b00011011.
- The package also holds the divider state enum.
- Sub-module div_iter: FSM, counter and sign fix-up; start/abort/signed in; busy/done/q/r out.

Test Plan:
- After reset release: all outputs 0, stall_o=0.
- OR: reg1=0x0000_1234, reg2=0x0000_00F0, wd=5, wreg=1 -> after edge N+1: wreg_o=1, wd_o=5, wdata_o=0x0000_12F4.
- SRA: reg1=4, reg2=0x8000_0000 -> wdata_o=0xF800_0000.
- SLT/SLTU: reg1=0xFFFF_FFFF, reg2=1 -> SLT gives 1, SLTU gives 0.
- DIV: reg1=0xFFFF_FFF9 (-7), reg2=2 -> stall_o high 33 cycles with bubbles. lo_o=0xFFFF_FFFD, hi_o=0xFFFF_FFFF. A following MFLO gives wdata_o=0xFFFF_FFFD.
- DIVU by 0: reg1=0x1234, reg2=0 -> stall_o high 1 cycle; lo_o=0xFFFF_FFFF, hi_o=0x1234.
- Abort: flush_i pulsed in BUSY cycle 10 of DIVU 100/7 -> stall_o=0 next cycle, hi_o/lo_o keep their prior values, ID/EX holds a NOP.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared opcode/result-class codes and divider state for the execute stage.
package cpu_defs_pkg;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_ARITH = 3'b100;
  localparam logic [2:0] RES_DIV   = 3'b101;

  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_ADDU = 8'b00100001;
  localparam logic [7:0] OP_SUBU = 8'b00100011;
  localparam logic [7:0] OP_SLT  = 8'b00101010;
  localparam logic [7:0] OP_SLTU = 8'b00101011;
  localparam logic [7:0] OP_MFHI = 8'b00010000;
  localparam logic [7:0] OP_MFLO = 8'b00010010;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input logic [2:0] sel, input logic [7:0] op);
    return (sel == RES_DIV) && ((op == OP_DIV) || (op == OP_DIVU));
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider: one quotient bit per cycle, signed fix-up on exit.
module div_iter
  import cpu_defs_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output div_state_t  state_o,
  output logic [31:0] q,
  output logic [31:0] r
);

  div_state_t  state;
  logic [31:0] rem, quo, dvs;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nxt, quo_nxt;

  always_comb begin
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvs};
    rem_nxt = rem_sh[31:0];
    quo_nxt = {quo[30:0], 1'b0};
    if (!diff[32]) begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (abort) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == 32'd0) begin
              quo   <= 32'hFFFF_FFFF;
              rem   <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DIV_DONE;
            end else begin
              quo   <= (signed_op && dividend[31]) ? -dividend : dividend;
              dvs   <= (signed_op && divisor[31]) ? -divisor : divisor;
              rem   <= '0;
              cnt   <= '0;
              neg_q <= signed_op && (dividend[31] ^ divisor[31]);
              neg_r <= signed_op && dividend[31];
              state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(DIV_CYCLES - 1)) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy    = ((state == DIV_IDLE) && start) || (state == DIV_BUSY);
  assign state_o = state;
  assign q       = neg_q ? -quo : quo;
  assign r       = neg_r ? -rem : rem;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, single-cycle ALU, iterative divider with HI/LO, EX/MEM register.
module ex_stage
  import cpu_defs_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        wreg_i,
  input  logic [4:0]  wd_i,
  output logic        stall_o,
  output logic        wreg_o,
  output logic [4:0]  wd_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1, ex_reg2;
  logic        ex_wreg;
  logic [4:0]  ex_wd;

  logic        div_start;
  logic [31:0] div_q, div_r;
  div_state_t  div_state;
  logic [31:0] result;
  logic        res_wreg;

  // stall_o is a hold request to decode: while high, ID/EX keeps its
  // contents and decode must present the same instruction again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush_i) begin
      ex_aluop  <= '0;
      ex_alusel <= RES_NOP;
      ex_reg1   <= '0;
      ex_reg2   <= '0;
      ex_wreg   <= 1'b0;
      ex_wd     <= '0;
    end else if (!stall_o) begin
      ex_aluop  <= aluop_i;
      ex_alusel <= alusel_i;
      ex_reg1   <= reg1_i;
      ex_reg2   <= reg2_i;
      ex_wreg   <= wreg_i;
      ex_wd     <= wd_i;
    end
  end

  assign div_start = is_div_op(ex_alusel, ex_aluop);

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush_i),
    .signed_op (ex_aluop == OP_DIV),
    .dividend  (ex_reg1),
    .divisor   (ex_reg2),
    .busy      (stall_o),
    .state_o   (div_state),
    .q         (div_q),
    .r         (div_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if ((div_state == DIV_DONE) && !flush_i) begin
      hi_o <= div_r;
      lo_o <= div_q;
    end
  end

  always_comb begin
    result   = '0;
    res_wreg = ex_wreg;
    case (ex_alusel)
      RES_LOGIC: case (ex_aluop)
        OP_OR:   result = ex_reg1 | ex_reg2;
        OP_AND:  result = ex_reg1 & ex_reg2;
        OP_XOR:  result = ex_reg1 ^ ex_reg2;
        OP_NOR:  result = ~(ex_reg1 | ex_reg2);
        default: result = '0;
      endcase
      RES_SHIFT: case (ex_aluop)
        OP_SLL:  result = ex_reg2 << ex_reg1[4:0];
        OP_SRL:  result = ex_reg2 >> ex_reg1[4:0];
        OP_SRA:  result = $unsigned($signed(ex_reg2) >>> ex_reg1[4:0]);
        default: result = '0;
      endcase
      RES_ARITH: case (ex_aluop)
        OP_ADDU: result = ex_reg1 + ex_reg2;
        OP_SUBU: result = ex_reg1 - ex_reg2;
        OP_SLT:  result = {31'd0, $signed(ex_reg1) < $signed(ex_reg2)};
        OP_SLTU: result = {31'd0, ex_reg1 < ex_reg2};
        default: result = '0;
      endcase
      RES_MOVE: case (ex_aluop)
        OP_MFHI: result = hi_o;
        OP_MFLO: result = lo_o;
        default: result = '0;
      endcase
      RES_DIV: result = '0;
      default: res_wreg = 1'b0;
    endcase
  end

  // Divides never write a GPR; the whole stall and the completion cycle are bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wreg_o  <= 1'b0;
      wd_o    <= '0;
      wdata_o <= '0;
    end else if (stall_o || (div_state == DIV_DONE)) begin
      wreg_o  <= 1'b0;
      wd_o    <= '0;
      wdata_o <= '0;
    end else begin
      wreg_o  <= res_wreg;
      wd_o    <= ex_wd;
      wdata_o <= result;
    end
  end

endmodule
